// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-controller bus: instruction-memory address/data plus the instruction
// handshake toward the consumer, redirect request and status.
interface imem_fetch_ctrl_if;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] Address;
    logic [31:0] Data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [31:0] fetch_count;
    logic        misalign_err;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, Data, inst_ready,
        output Address, inst_valid, inst, inst_pc, fetch_count, misalign_err
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, Data, inst_ready,
        input  Address, inst_valid, inst, inst_pc, fetch_count, misalign_err
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: holds Address for RD_LAT cycles, captures Data,
// presents it with a valid/ready handshake and honours PC redirects.
module imem_fetch_ctrl #(
    parameter int unsigned RD_LAT   = 2,
    parameter logic [63:0] START_PC = 64'h0
) (
    input logic               CLK,
    input logic               Reset_L,
    imem_fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    localparam logic [3:0] LAST = 4'(RD_LAT - 1);

    state_t      state;
    state_t      state_next;
    logic [63:0] pc;
    logic [3:0]  timer;
    logic [31:0] inst_q;
    logic [63:0] inst_pc_q;
    logic [31:0] count;
    logic        misalign;
    logic        handshake;
    logic        capture;

    assign handshake = (state == HOLD) && bus.inst_ready;
    // A redirect on the final WAIT edge aborts the read, so it must block capture.
    assign capture   = (state == WAIT) && (timer == LAST) && !bus.redirect_valid;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.fetch_en) state_next = WAIT;
            WAIT:    if (timer == LAST) state_next = HOLD;
            HOLD:    if (handshake) state_next = bus.fetch_en ? WAIT : IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.redirect_valid) begin
            state_next = bus.fetch_en ? WAIT : IDLE;
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            pc        <= START_PC;
            timer     <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            count     <= '0;
            misalign  <= 1'b0;
        end else begin
            if (handshake) begin
                count <= count + 32'd1;
            end
            if (bus.redirect_valid) begin
                pc <= {bus.redirect_pc[63:2], 2'b00};
            end else if (handshake) begin
                pc <= pc + 64'd4;
            end
            if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
                misalign <= 1'b1;
            end
            if (capture) begin
                inst_q    <= bus.Data;
                inst_pc_q <= pc;
            end
            if ((state == WAIT) && (state_next == WAIT) && !bus.redirect_valid) begin
                timer <= timer + 4'd1;
            end else begin
                timer <= '0;
            end
        end
    end

    always_comb begin
        bus.Address      = pc;
        bus.inst_valid   = (state == HOLD);
        bus.inst         = inst_q;
        bus.inst_pc      = inst_pc_q;
        bus.fetch_count  = count;
        bus.misalign_err = misalign;
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: transaction-level reference model feeding a
// scoreboard queue, directed scenarios followed by randomized traffic.
`timescale 1ns/1ps
module tb_imem_fetch_ctrl;

    localparam int unsigned RD_LAT   = 2;
    localparam logic [63:0] START_PC = 64'h0;
    localparam int          PERIOD   = 10;

    logic CLK = 1'b0;
    logic Reset_L = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(.RD_LAT(RD_LAT), .START_PC(START_PC)) dut (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .bus     (bus)
    );

    always #(PERIOD / 2) CLK = ~CLK;

    function automatic logic [31:0] imem(input logic [63:0] a);
        case (a)
            64'h00:  return 32'hF840_03E9;
            64'h04:  return 32'hF840_83EA;
            64'h1C:  return 32'hB400_0060;
            default: return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
        endcase
    endfunction

    // Memory only returns the real word once Address has been stable long enough.
    time         t_chg = 0;
    logic [63:0] ok_addr = '0;
    logic        ok_valid = 1'b0;

    always @(bus.Address) t_chg = $time;

    always @(negedge CLK) begin
        ok_valid = (($time - t_chg) >= time'(RD_LAT * PERIOD - PERIOD / 2));
        ok_addr  = bus.Address;
    end

    assign bus.Data = (ok_valid && (bus.Address == ok_addr)) ? imem(bus.Address) : 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] word;
        logic [63:0] pc;
    } fetch_t;

    fetch_t      sb[$];
    logic        m_held = 1'b0;
    logic        m_busy = 1'b0;
    int unsigned m_left = 0;
    logic [63:0] m_pc = START_PC;
    logic [31:0] m_cnt = '0;
    logic        m_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_held = 1'b0;
        m_busy = 1'b0;
        m_left = 0;
        m_pc   = START_PC;
        m_cnt  = '0;
        m_err  = 1'b0;
        sb.delete();
    endtask

    // One clock edge of the fetch stream: a started read completes RD_LAT edges later.
    task automatic model_step();
        logic hs;
        hs = m_held && bus.inst_ready;
        if (hs) begin
            m_cnt = m_cnt + 32'd1;
            m_pc  = m_pc + 64'd4;
        end
        if (bus.redirect_valid) begin
            if (m_held && !hs && sb.size() > 0) void'(sb.pop_front());
            m_held = 1'b0;
            m_pc   = {bus.redirect_pc[63:2], 2'b00};
            if (bus.redirect_pc[1:0] != 2'b00) m_err = 1'b1;
            m_busy = bus.fetch_en;
            m_left = RD_LAT;
        end else if (hs) begin
            m_held = 1'b0;
            m_busy = bus.fetch_en;
            m_left = RD_LAT;
        end else if (m_held) begin
            m_held = 1'b1;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_held = 1'b1;
                sb.push_back('{word: imem(m_pc), pc: m_pc});
            end
        end else if (bus.fetch_en) begin
            m_busy = 1'b1;
            m_left = RD_LAT;
        end
    endtask

    task automatic step(input logic fe, input logic rv, input logic [63:0] rpc, input logic rdy);
        bus.fetch_en       = fe;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.inst_ready     = rdy;
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        #1 Reset_L = 1'b0;
        #1;
        check("rst_Address", bus.Address, START_PC);
        check("rst_inst_valid", 64'(bus.inst_valid), 64'(0));
        check("rst_inst", 64'(bus.inst), 64'(0));
        check("rst_inst_pc", bus.inst_pc, 64'(0));
        check("rst_fetch_count", 64'(bus.fetch_count), 64'(0));
        check("rst_misalign_err", 64'(bus.misalign_err), 64'(0));
        model_reset();
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        repeat (2) @(posedge CLK);
        #3 Reset_L = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (Reset_L) begin
            check("inst_valid", 64'(bus.inst_valid), 64'(m_held));
            check("Address", bus.Address, m_pc);
            check("fetch_count", 64'(bus.fetch_count), 64'(m_cnt));
            check("misalign_err", 64'(bus.misalign_err), 64'(m_err));
            if (bus.inst_valid) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_inst: got inst_pc %h expected no instruction", bus.inst_pc);
                end else begin
                    check("inst", 64'(bus.inst), 64'(sb[0].word));
                    check("inst_pc", bus.inst_pc, sb[0].pc);
                    if (bus.inst_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic        fe, rv, rdy;
        logic [63:0] rpc;
        bus.fetch_en       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        @(posedge CLK);
        #1;
        do_reset();

        // Back-to-back fetches from 0x0 and 0x4
        repeat (7) step(1'b1, 1'b0, 64'h0, 1'b1);
        // Consumer stalls in HOLD
        repeat (8) step(1'b1, 1'b0, 64'h0, 1'b0);
        step(1'b1, 1'b0, 64'h0, 1'b1);
        // Redirect in the first WAIT cycle of the fetch at 0x28
        step(1'b1, 1'b1, 64'h28, 1'b0);
        step(1'b1, 1'b1, 64'h1C, 1'b0);
        repeat (4) step(1'b1, 1'b0, 64'h0, 1'b1);
        // Redirect coinciding with a handshake
        step(1'b1, 1'b1, 64'h28, 1'b0);
        repeat (3) step(1'b1, 1'b0, 64'h0, 1'b0);
        step(1'b1, 1'b1, 64'h1C, 1'b1);
        repeat (3) step(1'b1, 1'b0, 64'h0, 1'b1);
        // Misaligned redirect is sticky
        step(1'b1, 1'b1, 64'h1E, 1'b0);
        repeat (3) step(1'b1, 1'b0, 64'h0, 1'b1);
        step(1'b1, 1'b1, 64'h40, 1'b1);
        repeat (3) step(1'b1, 1'b0, 64'h0, 1'b1);
        // PC wraps past the top of the address space
        step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        repeat (6) step(1'b1, 1'b0, 64'h0, 1'b1);
        // fetch_en dropped mid-WAIT does not abort; then stays idle
        step(1'b1, 1'b1, 64'h100, 1'b0);
        repeat (4) step(1'b0, 1'b0, 64'h0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 64'h0, 1'b1);

        // Asynchronous reset in HOLD with seven instructions accepted
        do_reset();
        for (int i = 0; i < 60 && m_cnt < 32'd7; i++) step(1'b1, 1'b0, 64'h0, 1'b1);
        for (int i = 0; i < 10 && !m_held; i++) step(1'b1, 1'b0, 64'h0, 1'b0);
        check("hold_inst_valid", 64'(bus.inst_valid), 64'(1));
        check("hold_fetch_count", 64'(bus.fetch_count), 64'(7));
        do_reset();
        repeat (5) step(1'b1, 1'b0, 64'h0, 1'b1);

        for (int n = 0; n < 800; n++) begin
            fe  = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            rpc = 64'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom);
            if ($urandom_range(0, 15) == 0) rpc[63:32] = $urandom;
            step(fe, rv, rpc, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter RD_LAT, default 2, meaning the number of clock cycles Address is held stable before Data is sampled; legal range is 1..15.
REQ-002 SHALL have parameter START_PC, default 64'h0, meaning the fetch address after reset; it SHALL be word-aligned.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset_L  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fetch_en  input  1  permits a new fetch to start.
REQ-006 SHALL have port redirect_valid  input  1  one-cycle request to change the fetch PC (branch, CBZ or jump target).
REQ-007 SHALL have port redirect_pc  input  64  new fetch target, qualified by redirect_valid.
REQ-008 SHALL have port Address  output  64  address driven to the instruction memory.
REQ-009 SHALL have port Data  input  32  instruction word returned by the instruction memory.
REQ-010 SHALL have port inst_valid  output  1  inst/inst_pc hold a fetched instruction.
REQ-011 SHALL have port inst_ready  input  1  the consumer accepts the instruction this cycle.
REQ-012 SHALL have port inst  output  32  captured instruction word.
REQ-013 SHALL have port inst_pc  output  64  address from which inst was fetched.
REQ-014 SHALL have port fetch_count  output  32  number of accepted instructions; wraps modulo 2^32.
REQ-015 SHALL have port misalign_err  output  1  sticky flag set when a misaligned redirect is received.

Function
REQ-016 SHALL implement the states IDLE, WAIT, HOLD.
REQ-017 In IDLE, the block SHALL enter WAIT with the timer at 0 when fetch_en=1; otherwise it SHALL stay in IDLE.
REQ-018 Address SHALL always equal the internal pc and SHALL be constant for every cycle spent in WAIT.
REQ-019 In WAIT, the timer SHALL increment each cycle; on the edge where timer==RD_LAT-1, the block SHALL capture inst<=Data and inst_pc<=pc, and go to HOLD.
REQ-020 inst_valid SHALL be 1 exactly while in HOLD, giving a latency of RD_LAT cycles from WAIT entry to inst_valid=1.
REQ-021 In HOLD, inst, inst_pc and inst_valid SHALL be stable until a handshake occurs (inst_valid & inst_ready).
REQ-022 On a handshake, the block SHALL set pc<=pc+4 (64-bit wrap) and fetch_count<=fetch_count+1, then go to WAIT with timer 0 if fetch_en=1, else to IDLE.
REQ-023 A redirect (redirect_valid=1) in any state SHALL set pc<={redirect_pc[63:2],2'b00}, clear the timer, and set the next state to WAIT if fetch_en=1, else IDLE.
REQ-024 Any HOLD instruction not handshaken in the redirect cycle SHALL be discarded, and inst_valid SHALL be 0 on the next cycle.
REQ-025 When a redirect and a handshake coincide, the handshake SHALL count (fetch_count increments), and the redirect target SHALL override pc+4.
REQ-026 A redirect during WAIT SHALL abort the in-flight read, and Data from the aborted read SHALL never be captured.
REQ-027 A redirect with redirect_pc[1:0]!=0 SHALL set misalign_err=1; only reset SHALL clear misalign_err.
REQ-028 A deassertion of fetch_en SHALL not abort an in-progress WAIT or HOLD; it SHALL only take effect at the next fetch-start decision.
REQ-029 Back-to-back throughput SHALL be one instruction per RD_LAT+1 cycles when inst_ready is held at 1.

Reset
REQ-030 When Reset_L=0, the block SHALL immediately, without waiting for a clock edge, set: state=IDLE, pc=START_PC, Address=START_PC, timer=0, inst_valid=0, inst=32'h0, inst_pc=64'h0, fetch_count=0, misalign_err=0.
REQ-031 An assertion of Reset_L in mid-WAIT or mid-HOLD SHALL discard the pending fetch; the first post-reset fetch SHALL be from START_PC.
REQ-032 Release of Reset_L SHALL take effect at the next rising edge; with fetch_en=1 at that edge, the block SHALL enter WAIT.

Verification
REQ-033 Test 1: RD_LAT=2, fetch_en=1, inst_ready=1, memory 0x0->F84003E9, 0x4->F84083EA -> inst_valid at cycles 2 and 5 after WAIT entry, inst=F84003E9 (inst_pc=0) then F84083EA (inst_pc=4), fetch_count=2.
REQ-034 Test 2: inst_ready=0 for 5 cycles in HOLD, then 1 -> inst and inst_pc stable throughout; exactly one increment of fetch_count; the next Address=0x4.
REQ-035 Test 3: redirect_valid=1 with redirect_pc=0x1C in the first WAIT cycle of fetch 0x28 -> inst_valid is never asserted for 0x28; the next instruction is inst_pc=0x1C, inst=B4000060.
REQ-036 Test 4: redirect and handshake in the same HOLD cycle (inst_pc=0x28, redirect_pc=0x1C) -> fetch_count +1; the next Address=0x1C, not 0x2C.
REQ-037 Test 5: redirect_pc=0x1E -> Address=0x1C and misalign_err=1, which remains set after further redirects.
REQ-038 Test 6: Reset_L pulsed low in mid-HOLD with fetch_count=7 -> all outputs take their reset values asynchronously, and after release the first fetch is from START_PC.
